// File: rtl/ng_run_ctrl.sv
// -----------------------------------------------------------------------------
// ng_run_ctrl
//   Run-control sequencer for the nandgame core. Fetches the instruction at the
//   core's PC over a req/ack handshake, presents it on instr and pulses
//   core_step for one cycle per instruction (core_step is the core's clock
//   enable). Supports run / halt / single-step, a fetch timeout that parks the
//   sequencer in FAULT, a retired-instruction counter and an optional PC
//   breakpoint.
//
//   Optional feature macro: NG_BREAKPOINT_EN (adds bp_addr and the comparator;
//   without it bp_hit is tied low).
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   pc                   current core PC
//   mem_req/mem_addr     fetch request (held until mem_ack) and fetch address
//   mem_ack/mem_rdata    fetch completion and instruction word
//   instr, core_step     instruction to the core and its one-cycle enable
//   cmd_run/halt/step    host command pulses (halt > run > step)
//   bp_addr              breakpoint PC (NG_BREAKPOINT_EN only)
//   running/halted/fault state flags
//   bp_hit               sticky breakpoint indication
//   retired              count of core_step pulses (wraps)
// -----------------------------------------------------------------------------
module ng_run_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      pc,
  output logic             mem_req,
  output logic [15:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [15:0]      mem_rdata,
  output logic [15:0]      instr,
  output logic             core_step,
  input  logic             cmd_run,
  input  logic             cmd_halt,
  input  logic             cmd_step,
`ifdef NG_BREAKPOINT_EN
  input  logic [15:0]      bp_addr,
`endif
  output logic             running,
  output logic             halted,
  output logic             fault,
  output logic             bp_hit,
  output logic [CNT_W-1:0] retired
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_HALT, S_FETCH, S_EXEC, S_FAULT} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             step_mode_q, step_mode_d;
  logic             halt_pend_q, halt_pend_d;
  logic             req_d, step_d, bp_hit_d;
  logic [15:0]      instr_d;
  logic [CNT_W-1:0] retired_d;
`ifdef NG_BREAKPOINT_EN
  // Set for the first FETCH cycle after a free-run EXEC: the core's PC has
  // only just advanced, so the compare happens here before any request.
  logic             bp_chk_q, bp_chk_d;
`endif

  // pc only moves on core_step, so it is stable for the whole request.
  assign mem_addr = mem_req ? pc : 16'h0000;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    timer_d     = timer_q;
    step_mode_d = step_mode_q;
    halt_pend_d = halt_pend_q;
    req_d       = mem_req;
    step_d      = 1'b0;
    instr_d     = instr;
    retired_d   = retired;
    bp_hit_d    = bp_hit;
`ifdef NG_BREAKPOINT_EN
    bp_chk_d    = bp_chk_q;
`endif

    unique case (state_q)
      S_HALT, S_FAULT: begin
        // cmd_halt has priority and is otherwise a no-op here; cmd_step
        // cannot leave FAULT.
        if (!cmd_halt && (cmd_run || (cmd_step && state_q == S_HALT))) begin
          state_d     = S_FETCH;
          step_mode_d = !cmd_run;
          halt_pend_d = 1'b0;
          bp_hit_d    = 1'b0;
          req_d       = 1'b1;
          timer_d     = '0;
        end
      end

      S_FETCH: begin
        if (cmd_halt) halt_pend_d = 1'b1;
`ifdef NG_BREAKPOINT_EN
        if (bp_chk_q) begin
          bp_chk_d = 1'b0;
          if (pc == bp_addr) begin
            state_d     = S_HALT;
            bp_hit_d    = 1'b1;
            halt_pend_d = 1'b0;
          end else begin
            req_d   = 1'b1;
            timer_d = '0;
          end
        end else
`endif
        if (mem_ack) begin
          // An ack in the TIMEOUT cycle still completes the fetch.
          instr_d = mem_rdata;
          req_d   = 1'b0;
          step_d  = 1'b1;
          state_d = S_EXEC;
        end else if (timer_q == TW'(TIMEOUT)) begin
          req_d   = 1'b0;
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_EXEC: begin
        retired_d = retired + 1'b1;
        // A halt arriving during EXEC still stops after this instruction.
        if (step_mode_q || halt_pend_q || cmd_halt) begin
          state_d     = S_HALT;
          halt_pend_d = 1'b0;
        end else begin
          state_d = S_FETCH;
`ifdef NG_BREAKPOINT_EN
          bp_chk_d = 1'b1;
`else
          req_d   = 1'b1;
          timer_d = '0;
`endif
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HALT;
      timer_q     <= '0;
      step_mode_q <= 1'b0;
      halt_pend_q <= 1'b0;
      mem_req     <= 1'b0;
      instr       <= 16'h0000;
      core_step   <= 1'b0;
      retired     <= '0;
      bp_hit      <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b1;
      fault       <= 1'b0;
`ifdef NG_BREAKPOINT_EN
      bp_chk_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      step_mode_q <= step_mode_d;
      halt_pend_q <= halt_pend_d;
      mem_req     <= req_d;
      instr       <= instr_d;
      core_step   <= step_d;
      retired     <= retired_d;
      bp_hit      <= bp_hit_d;
      running     <= (state_d == S_FETCH) || (state_d == S_EXEC);
      halted      <= (state_d == S_HALT);
      fault       <= (state_d == S_FAULT);
`ifdef NG_BREAKPOINT_EN
      bp_chk_q    <= bp_chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_ng_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ng_run_ctrl
//   Scoreboard bench for ng_run_ctrl. A memory responder acknowledges fetches
//   and pushes the expected {pc, word, ack cycle} into a queue; a monitor pops
//   one entry per core_step and compares instr, pc and ack-to-step latency.
//   Scenario code drives host commands and checks state, timeout and counter
//   expectations derived from the run-control rules.
// -----------------------------------------------------------------------------
module tb_ng_run_ctrl;

  localparam int TO = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   pc;
  logic          mem_req;
  logic [15:0]   mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_rdata;
  logic [15:0]   instr;
  logic          core_step;
  logic          cmd_run, cmd_halt, cmd_step;
  logic          running, halted, fault, bp_hit;
  logic [CW-1:0] retired;
`ifdef NG_BREAKPOINT_EN
  logic [15:0]   bp_addr;
`endif

  ng_run_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .core_step(core_step),
    .cmd_run(cmd_run), .cmd_halt(cmd_halt), .cmd_step(cmd_step),
`ifdef NG_BREAKPOINT_EN
    .bp_addr(bp_addr),
`endif
    .running(running), .halted(halted), .fault(fault), .bp_hit(bp_hit),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } fetch_t;

  fetch_t      sb[$];
  logic [15:0] imem [0:255];
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          n_push   = 0;
  int          n_steps  = 0;
  int          fix_lat  = 0;   // < 0 selects a random 0..3 cycle latency
  bit          ack_en   = 1'b1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Core model: PC advances by one on every core_step, clears on reset.
  initial begin
    bit s;
    pc = 16'h0000;
    forever begin
      @(negedge clk);
      s = core_step;
      @(posedge clk);
      #1;
      if (rst) pc = 16'h0000;
      else if (s) pc = pc + 16'h0001;
    end
  end

  // Memory responder: acknowledges each request after a chosen latency and
  // records what the core should then execute.
  initial begin
    bit     seen;
    int     wc;
    fetch_t f;
    seen = 1'b0; wc = 0;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req || rst) begin
        seen = 1'b0;
      end else if (ack_en) begin
        if (!seen) begin
          seen = 1'b1;
          wc   = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
        end
        if (wc == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = imem[mem_addr[7:0]];
          check("fetch_addr", mem_addr, pc);
          f.addr = pc; f.data = mem_rdata; f.cyc = cyc;
          sb.push_back(f);
          n_push++;
          seen = 1'b0;
        end else begin
          wc--;
        end
      end
    end
  end

  // Monitor: one scoreboard entry per core_step pulse.
  initial begin
    fetch_t f;
    bit     prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (core_step) begin
        n_steps++;
        check("step_spacing", prev, 0);
        if (sb.size() == 0) begin
          check("step_unexpected", core_step, 0);
        end else begin
          f = sb.pop_front();
          check("instr", instr, f.data);
          check("step_pc", pc, f.addr);
          check("step_latency", cyc, f.cyc + 1);
        end
      end
      prev = core_step;
    end
  end

  task automatic cmd(input bit r, input bit h, input bit s);
    @(negedge clk);
    cmd_run = r; cmd_halt = h; cmd_step = s;
    @(negedge clk);
    cmd_run = 1'b0; cmd_halt = 1'b0; cmd_step = 1'b0;
  endtask

  task automatic wait_halted(input string nm, input int budget);
    int i = 0;
    while (!halted && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(nm, halted, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, i, r_cyc, f_cyc, exp_ret, k;
    rst = 1'b1;
    cmd_run = 1'b0; cmd_halt = 1'b0; cmd_step = 1'b0;
`ifdef NG_BREAKPOINT_EN
    bp_addr = 16'hFFFF;
`endif
    for (int a = 0; a < 256; a++) imem[a] = 16'($urandom);
    imem[0] = 16'h8C10;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset
    repeat (10) @(negedge clk);
    check("t1_halted", halted, 1);
    check("t1_running", running, 0);
    check("t1_fault", fault, 0);
    check("t1_mem_req", mem_req, 0);
    check("t1_core_step", core_step, 0);
    check("t1_retired", retired, 0);
    check("t1_instr", instr, 0);

    // 2: single step, ack one cycle after request
    fix_lat = 1; exp_ret = 0;
    cmd(0, 0, 1);
    wait_halted("t2_halted", 20);
    exp_ret = exp_ret + 1;
    check("t2_instr", instr, 16'h8C10);
    check("t2_retired", retired, exp_ret);
    check("t2_steps", n_steps, 1);

    // 3: free-run with 0-wait memory, halt during the sixth fetch
    fix_lat = 0; base = n_steps;
    cmd(1, 0, 0);
    i = 0;
    while (n_steps - base < 5 && i < 100) begin
      @(posedge clk);
      i++;
    end
    check("t3_five_steps", n_steps - base, 5);
    @(negedge clk);
    i = 0;
    while (!mem_req && i < 10) begin
      @(negedge clk);
      i++;
    end
    cmd_halt = 1'b1;
    @(negedge clk);
    cmd_halt = 1'b0;
    wait_halted("t3_halted", 20);
    exp_ret = exp_ret + 6;
    check("t3_retired", retired, exp_ret);
    check("t3_steps", n_steps - base, 6);

    // Ack in the TIMEOUT cycle beats the timeout
    fix_lat = TO;
    cmd(0, 0, 1);
    wait_halted("tb_ack_at_timeout", 30);
    exp_ret = exp_ret + 1;
    check("tb_no_fault", fault, 0);
    check("tb_retired", retired, exp_ret);

    // 4: timeout to FAULT, step ignored, run restarts
    ack_en = 1'b0;
    cmd(1, 0, 0);
    i = 0;
    while (!mem_req && i < 10) begin
      @(negedge clk);
      i++;
    end
    r_cyc = cyc;
    i = 0;
    while (!fault && i < 20) begin
      @(negedge clk);
      i++;
    end
    f_cyc = cyc;
    check("t4_fault", fault, 1);
    check("t4_fault_delay", f_cyc - r_cyc, TO + 1);
    check("t4_req_drop", mem_req, 0);
    check("t4_running", running, 0);
    cmd(0, 0, 1);
    repeat (3) @(negedge clk);
    check("t4_step_ignored", fault, 1);
    check("t4_step_no_req", mem_req, 0);
    cmd(0, 1, 0);
    check("t4_halt_ignored", fault, 1);
    ack_en = 1'b1; fix_lat = 2;
    cmd(1, 0, 0);
    check("t4_restart_fault", fault, 0);
    check("t4_restart_req", mem_req, 1);
    check("t4_restart_addr", mem_addr, pc);
    cmd(0, 1, 0);
    wait_halted("t4_halted", 20);
    exp_ret = exp_ret + 1;
    check("t4_retired", retired, exp_ret);

    // Randomised runs and step bursts
    fix_lat = -1;
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        cmd(1, 0, 0);
        repeat ($urandom_range(3, 30)) @(negedge clk);
        cmd(0, 1, 0);
        wait_halted("rand_run_halted", 50);
        exp_ret = n_push;
      end else begin
        k = int'($urandom_range(1, 3));
        for (int j = 0; j < k; j++) begin
          cmd(0, 0, 1);
          wait_halted("rand_step_halted", 30);
        end
        exp_ret = exp_ret + k;
      end
      check("rand_retired", retired, exp_ret);
      check("rand_sb_empty", sb.size(), 0);
      check("rand_bp_clear", bp_hit, 0);
    end

    // 6: reset during a fetch is immediate
    ack_en = 1'b0;
    cmd(1, 0, 0);
    repeat (2) @(negedge clk);
    check("t6_pre_req", mem_req, 1);
    rst = 1'b1;
    #1;
    check("t6_mem_req", mem_req, 0);
    check("t6_mem_addr", mem_addr, 0);
    check("t6_instr", instr, 0);
    check("t6_core_step", core_step, 0);
    check("t6_retired", retired, 0);
    check("t6_halted", halted, 1);
    check("t6_running", running, 0);
    check("t6_fault", fault, 0);
    check("t6_bp_hit", bp_hit, 0);
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1; fix_lat = 0;
    cmd(1, 1, 0);
    repeat (4) @(negedge clk);
    check("t6_halt_run_halted", halted, 1);
    check("t6_halt_run_no_req", mem_req, 0);
    cmd(0, 1, 1);
    repeat (4) @(negedge clk);
    check("t6_halt_step_halted", halted, 1);
    check("t6_halt_step_retired", retired, 0);

`ifdef NG_BREAKPOINT_EN
    // 5: breakpoint at PC 3, resume from it
    bp_addr = 16'h0003;
    cmd(1, 0, 0);
    wait_halted("t5_bp_halted", 60);
    check("t5_pc", pc, 16'h0003);
    check("t5_bp_hit", bp_hit, 1);
    check("t5_retired", retired, 3);
    fix_lat = 2;
    cmd(1, 0, 0);
    check("t5_bp_cleared", bp_hit, 0);
    check("t5_resume_req", mem_req, 1);
    check("t5_resume_addr", mem_addr, 16'h0003);
    cmd(0, 1, 0);
    wait_halted("t5_halted", 20);
    check("t5_retired_after", retired, 4);
    bp_addr = 16'hFFFF;
`else
    // Without the breakpoint feature a run straight past PC 3 never flags.
    fix_lat = 0;
    cmd(1, 0, 0);
    repeat (16) @(negedge clk);
    cmd(0, 1, 0);
    wait_halted("nobp_halted", 20);
    check("nobp_bp_hit", bp_hit, 0);
    check("nobp_retired", retired, pc);
`endif

    repeat (5) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
